interrupt_sequencer: RTL

// Parametrised 6502-style interrupt/RTI sequencer for the CPU core. Latches or samples NUM_SRC hardware sources,

---
 rtl/interrupt_sequencer_if.sv | 25 ++
 rtl/interrupt_sequencer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/interrupt_sequencer_if.sv
// CPU bus as seen by the interrupt sequencer: it drives the address, write data
// and strobe while busy, and the memory returns read data one cycle later.
interface interrupt_sequencer_if;
   logic [15:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic        mem_we;
   logic [7:0]  mem_rdata;
   logic        busy;

   modport master (
      output mem_addr,
      output mem_wdata,
      output mem_we,
      output busy,
      input  mem_rdata
   );

   modport slave (
      input  mem_addr,
      input  mem_wdata,
      input  mem_we,
      input  busy,
      output mem_rdata
   );
endinterface

// File: rtl/interrupt_sequencer.sv
// 6502-style interrupt/RTI sequencer: arbitrates hardware sources, BRK and RTI at
// the instruction boundary, runs the stack push/pull and vector fetch, returns PC/P/S.
module interrupt_sequencer #(
   parameter int unsigned            NUM_SRC    = 3,
   parameter logic [NUM_SRC*16-1:0]  VEC_MAP    = {16'hFFFE, 16'hFFFA, 16'hFFFC},
   parameter logic [NUM_SRC-1:0]     EDGE_MASK  = 3'b011,
   parameter logic [NUM_SRC-1:0]     MASK_I     = 3'b100,
   parameter logic [NUM_SRC-1:0]     NO_PUSH    = 3'b001,
   parameter logic [15:0]            BRK_VEC    = 16'hFFFE,
   parameter logic [7:0]             STACK_PAGE = 8'h01
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_SRC-1:0]   irq_src,
   input  logic                 brk_req,
   input  logic                 is_rti,
   input  logic                 start,
   input  logic [15:0]          pc_in,
   input  logic [7:0]           status_in,
   input  logic [7:0]           sp_in,
   interrupt_sequencer_if.master bus,
   output logic                 done,
   output logic [15:0]          pc_out,
   output logic [7:0]           status_out,
   output logic [7:0]           sp_out,
   output logic [NUM_SRC-1:0]   ack_src,
   output logic [NUM_SRC-1:0]   pending
);

   typedef enum logic [3:0] {
      S_IDLE, S_PUSH_PCH, S_PUSH_PCL, S_PUSH_P, S_VEC_LO, S_VEC_HI,
      S_RD_END, S_PULL_P, S_PULL_PCL, S_PULL_PCH, S_DONE
   } state_t;

   typedef enum logic [1:0] {K_PASS, K_HW, K_BRK, K_RTI} kind_t;

   localparam logic [NUM_SRC-1:0] ONE_SRC = {{(NUM_SRC-1){1'b0}}, 1'b1};

   state_t               state_q, state_d;
   kind_t                kind_q, kind_d;
   logic [NUM_SRC-1:0]   src_q, src_d;
   logic [15:0]          vec_q, vec_d;
   logic [15:0]          pc_q, pc_d;
   logic [7:0]           p_q, p_d;
   logic [7:0]           s_q, s_d;
   logic [7:0]           lo_q, lo_d;
   logic [7:0]           rp_q, rp_d;
   logic [NUM_SRC-1:0]   hist_q, pend_q, pend_d;
   logic [15:0]          addr_q, addr_d;
   logic [7:0]           wdata_q, wdata_d;
   logic                 we_q, we_d;
   logic                 done_q, done_d;
   logic [15:0]          pc_out_q, pc_out_d;
   logic [7:0]           status_out_q, status_out_d;
   logic [7:0]           sp_out_q, sp_out_d;
   logic [NUM_SRC-1:0]   ack_q, ack_d;

   logic [NUM_SRC-1:0]   pend_s, elig_s, lowest_s, clr_s;
   logic [15:0]          sel_vec_s;
   logic                 sel_found_s, sel_nopush_s;

   // Edge sources use the latched bit, level sources are seen live.
   assign pend_s   = (pend_q & EDGE_MASK) | (irq_src & ~EDGE_MASK);
   assign elig_s   = pend_s & ~(MASK_I & {NUM_SRC{status_in[2]}});
   assign lowest_s = elig_s & (~elig_s + ONE_SRC);
   assign clr_s    = (state_q == S_VEC_LO) ? src_q : '0;
   assign pend_d   = ((pend_q & ~clr_s) | (irq_src & ~hist_q)) & EDGE_MASK;

   // Vector and push policy of the winning source
   always_comb begin
      sel_vec_s    = 16'h0000;
      sel_found_s  = |elig_s;
      sel_nopush_s = |(lowest_s & NO_PUSH);
      for (int i = 0; i < NUM_SRC; i++) begin
         sel_vec_s = sel_vec_s | ({16{lowest_s[i]}} & VEC_MAP[16*i +: 16]);
      end
   end

   // Next state, start-cycle context and read-data captures
   always_comb begin
      state_d = state_q;
      kind_d  = kind_q;
      src_d   = src_q;
      vec_d   = vec_q;
      pc_d    = pc_q;
      p_d     = p_q;
      s_d     = s_q;
      lo_d    = lo_q;
      rp_d    = rp_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               pc_d  = pc_in;
               p_d   = status_in;
               s_d   = sp_in;
               src_d = '0;
               vec_d = BRK_VEC;
               if (is_rti) begin
                  kind_d  = K_RTI;
                  state_d = S_PULL_P;
               end else if (sel_found_s) begin
                  kind_d  = K_HW;
                  src_d   = lowest_s;
                  vec_d   = sel_vec_s;
                  state_d = sel_nopush_s ? S_VEC_LO : S_PUSH_PCH;
               end else if (brk_req) begin
                  kind_d  = K_BRK;
                  state_d = S_PUSH_PCH;
               end else begin
                  kind_d  = K_PASS;
                  state_d = S_DONE;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_PUSH_PCH: state_d = S_PUSH_PCL;
         S_PUSH_PCL: state_d = S_PUSH_P;
         S_PUSH_P:   state_d = S_VEC_LO;
         S_VEC_LO:   state_d = S_VEC_HI;
         S_VEC_HI: begin
            lo_d    = bus.mem_rdata;
            state_d = S_RD_END;
         end
         S_RD_END:   state_d = S_DONE;
         S_PULL_P:   state_d = S_PULL_PCL;
         S_PULL_PCL: begin
            rp_d    = bus.mem_rdata;
            state_d = S_PULL_PCH;
         end
         S_PULL_PCH: begin
            lo_d    = bus.mem_rdata;
            state_d = S_RD_END;
         end
         S_DONE:     state_d = S_IDLE;
         default:    state_d = S_IDLE;
      endcase
   end

   // Bus and result values for the state being entered; the high byte arrives in RD_END
   always_comb begin
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      we_d         = 1'b0;
      done_d       = 1'b0;
      pc_out_d     = pc_out_q;
      status_out_d = status_out_q;
      sp_out_d     = sp_out_q;
      ack_d        = ack_q;
      case (state_d)
         S_PUSH_PCH: begin
            we_d    = 1'b1;
            addr_d  = {STACK_PAGE, s_d};
            wdata_d = pc_d[15:8];
         end
         S_PUSH_PCL: begin
            we_d    = 1'b1;
            addr_d  = {STACK_PAGE, s_d - 8'd1};
            wdata_d = pc_d[7:0];
         end
         S_PUSH_P: begin
            we_d    = 1'b1;
            addr_d  = {STACK_PAGE, s_d - 8'd2};
            wdata_d = (p_d & 8'hEF) | 8'h20 | {3'b000, (kind_d == K_BRK), 4'b0000};
         end
         S_VEC_LO:   addr_d = vec_d;
         S_VEC_HI:   addr_d = vec_d + 16'd1;
         S_PULL_P:   addr_d = {STACK_PAGE, s_d + 8'd1};
         S_PULL_PCL: addr_d = {STACK_PAGE, s_d + 8'd2};
         S_PULL_PCH: addr_d = {STACK_PAGE, s_d + 8'd3};
         S_DONE: begin
            done_d = 1'b1;
            case (kind_d)
               K_PASS: begin
                  pc_out_d     = pc_d;
                  status_out_d = p_d;
                  sp_out_d     = s_d;
                  ack_d        = '0;
               end
               K_RTI: begin
                  pc_out_d     = {bus.mem_rdata, lo_q};
                  status_out_d = {rp_q[7:6], p_d[5:4], rp_q[3:0]};
                  sp_out_d     = s_d + 8'd3;
                  ack_d        = '0;
               end
               default: begin
                  pc_out_d     = {bus.mem_rdata, lo_q};
                  status_out_d = p_d | 8'h04;
                  sp_out_d     = s_d - 8'd3;
                  ack_d        = src_d;
               end
            endcase
         end
         default: begin
            addr_d = addr_q;
            we_d   = 1'b0;
         end
      endcase
   end

   // State register, context, pending latches and registered outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= S_IDLE;
         kind_q       <= K_PASS;
         src_q        <= '0;
         vec_q        <= 16'h0000;
         pc_q         <= 16'h0000;
         p_q          <= 8'h00;
         s_q          <= 8'h00;
         lo_q         <= 8'h00;
         rp_q         <= 8'h00;
         hist_q       <= '0;
         pend_q       <= '0;
         addr_q       <= 16'h0000;
         wdata_q      <= 8'h00;
         we_q         <= 1'b0;
         done_q       <= 1'b0;
         pc_out_q     <= 16'h0000;
         status_out_q <= 8'h00;
         sp_out_q     <= 8'h00;
         ack_q        <= '0;
      end else begin
         state_q      <= state_d;
         kind_q       <= kind_d;
         src_q        <= src_d;
         vec_q        <= vec_d;
         pc_q         <= pc_d;
         p_q          <= p_d;
         s_q          <= s_d;
         lo_q         <= lo_d;
         rp_q         <= rp_d;
         hist_q       <= irq_src;
         pend_q       <= pend_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         we_q         <= we_d;
         done_q       <= done_d;
         pc_out_q     <= pc_out_d;
         status_out_q <= status_out_d;
         sp_out_q     <= sp_out_d;
         ack_q        <= ack_d;
      end
   end

   assign bus.mem_addr  = addr_q;
   assign bus.mem_wdata = wdata_q;
   assign bus.mem_we    = we_q;
   assign bus.busy      = (state_q != S_IDLE);
   assign done          = done_q;
   assign pc_out        = pc_out_q;
   assign status_out    = status_out_q;
   assign sp_out        = sp_out_q;
   assign ack_src       = ack_q;
   assign pending       = pend_s;

endmodule
